cxd2545_cmd_receiver: RTL
=========================

// Module: cxd2545_cmd_receiver
// PURPOSE
//  Upstream stage of the CXD2545 track counter. It deserialises the MCU servo
//  command bus (DATA/CLOK/XLAT) into latched 8/16/24-bit command words and
//  decodes tracking-mode commands. From those it drives jump_active, which
//  feeds the track counter's trigger input: high for the length of a track
//  jump, low otherwise.
// PARAMETERS
//  SYNC_STAGES  2     flip-flop stages synchronising data/clok/xlat into clk (>=2)
//  MAX_BITS     24    shift register depth; longest legal command word
//  TRK_ADDR     4'h2  command address of the tracking-mode command
// PORTS
//  clk          in   1   system clock (same clock as the track counter)
//  reset        in   1   asynchronous, active-high reset
//  data         in   1   MCU serial data; asynchronous to clk
//  clok         in   1   MCU serial clock; data is sampled on its rising edge
//  xlat         in   1   MCU latch; the word is committed on its falling edge
//  cmd_addr     out  4   address nibble of the last accepted word
//  cmd_data     out  20  remaining bits of that word, right-aligned, zero-filled
//  cmd_len      out  2   1 = 8-bit, 2 = 16-bit, 3 = 24-bit word
//  cmd_strobe   out  1   one-clk pulse when cmd_* are updated
//  len_err      out  1   one-clk pulse when a latch is rejected
//  jump_active  out  1   track-jump in progress; drives track counter trigger
// BEHAVIOUR
//  - Reset: every output is 0; the shift register, bit_cnt and FSM clear to IDLE.
//    Reset asserted mid-word discards the partial word.
//  - Input path: SYNC_STAGES flops per input, then one registered copy for edge
//    detection. All logic uses only the synchronised signals.
//  - Bit order is MSB first: shreg <= {shreg[MAX_BITS-2:0], data_s} on each
//    synchronised clok rise. bit_cnt saturates at MAX_BITS+1.
//  - FSM states:
//    * IDLE: bit_cnt = 0. A clok rise shifts one bit and moves to SHIFT.
//    * SHIFT: clok rises shift. When bit_cnt would exceed MAX_BITS, go to OVFL.
//    * OVFL: further clok rises are ignored.
//    * From any state, an xlat fall runs the latch check, then returns to IDLE
//      and clears bit_cnt and shreg.
//  - Clock rises while xlat_s is low are ignored; no shift takes place.
//  - Simultaneous clok rise and xlat fall in one cycle: the bit shifts first,
//    and the latch check uses the updated count and register.
//  - Latch check:
//    * bit_cnt in {8,16,24}: cmd_addr = shreg[bit_cnt-1 -: 4],
//      cmd_data = shreg[bit_cnt-5:0] zero-extended, cmd_len = bit_cnt/8.
//      cmd_strobe pulses in the same cycle that the outputs update.
//    * Any other count, including 0 and OVFL: len_err pulses, cmd_* hold, and
//      jump_active is unchanged.
//  - Latency: cmd_strobe/len_err rise SYNC_STAGES+2 clk edges after the first
//    clk edge that samples xlat low.
//  - jump_active is updated only on an accepted word with cmd_addr == TRK_ADDR.
//    Its tracking field is cmd_data[cmd_len*8-5 -: 2], the top two bits of the
//    low nibble of the first byte:
//    * 2'b10 (FWD jump) or 2'b11 (REV jump): set to 1.
//    * 2'b00 or 2'b01 (servo off/on): clear to 0.
//    It changes in the cmd_strobe cycle. Repeat jump commands keep it at 1, with
//    no glitch.
//  - Words with another address update cmd_* but leave jump_active unchanged.
// TESTING
//  1 Reset mid-word: shift 5 bits, assert reset, then send a clean 8-bit 0x28
//    -> all outputs 0 during reset; afterwards exactly one cmd_strobe with
//    addr=2, data=0x8, len=1, and jump_active=1.
//  2 16-bit word 0x5ABC MSB first, then xlat pulse -> cmd_addr=5,
//    cmd_data=0x00ABC, cmd_len=2, one strobe SYNC_STAGES+2 clks after xlat is
//    sampled low, jump_active unchanged.
//  3 Jump FWD 0x28, then servo-on 0x25 -> jump_active goes 0->1 on the first
//    strobe and 1->0 on the second. A 2nd 0x28 while high causes no glitch.
//  4 Bad counts: 12 bits, then 0 bits, then 30 bits, each followed by an xlat
//    pulse -> three len_err pulses, no cmd_strobe, cmd_* hold, and the next
//    8-bit word is accepted.
//  5 clok rise and xlat fall in the same synchronised cycle on the 8th bit
//    -> the word is accepted with len=1. A clok rise with xlat low -> no shift.
//  6 24-bit 0x2C1234 -> addr=2, data=0xC1234, len=3, jump_active=1 (REV).

Source files
------------

// File: rtl/cxd2545_cmd_receiver.sv
// cxd2545_cmd_receiver
// Front end of the CXD2545 track counter. Deserialises the MCU servo command
// bus (data/clok/xlat) into 8/16/24-bit command words, MSB first, and decodes
// tracking-mode commands into jump_active, which drives the track counter's
// trigger input for the duration of a track jump.
//
// Ports:
//   clk          system clock, shared with the track counter
//   reset        asynchronous, active-high reset
//   data         MCU serial data, asynchronous to clk
//   clok         MCU serial clock, data sampled on its rising edge
//   xlat         MCU latch, the word is committed on its falling edge
//   cmd_addr     address nibble of the last accepted word
//   cmd_data     remaining word bits, right-aligned, zero-filled
//   cmd_len      1 = 8-bit, 2 = 16-bit, 3 = 24-bit word
//   cmd_strobe   one-clk pulse when cmd_* update
//   len_err      one-clk pulse when a latch is rejected
//   jump_active  high while a track jump is in progress

module cxd2545_cmd_receiver #(
   parameter int         SYNC_STAGES = 2,
   parameter int         MAX_BITS    = 24,
   parameter logic [3:0] TRK_ADDR    = 4'h2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data,
   input  logic        clok,
   input  logic        xlat,
   output logic [3:0]  cmd_addr,
   output logic [19:0] cmd_data,
   output logic [1:0]  cmd_len,
   output logic        cmd_strobe,
   output logic        len_err,
   output logic        jump_active
);

   localparam int CNT_W = $clog2(MAX_BITS + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OVFL  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] data_sync;
   logic [SYNC_STAGES-1:0] clok_sync;
   logic [SYNC_STAGES-1:0] xlat_sync;
   logic                   data_s;
   logic                   clok_s;
   logic                   xlat_s;
   logic                   clok_d;
   logic                   xlat_d;
   logic                   shift_req;
   logic                   latch_req;
   logic                   rise_r;
   logic                   fall_r;
   logic                   bit_r;

   state_t                 state;
   state_t                 state_n;
   logic [MAX_BITS-1:0]    shreg;
   logic [MAX_BITS-1:0]    shift_word;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       shift_cnt;

   logic [MAX_BITS-1:0]    lat_word;
   logic [CNT_W-1:0]       lat_cnt;
   logic                   lat_pend;

   logic [23:0]            w24;
   logic                   dec_ok;
   logic [3:0]             dec_addr;
   logic [19:0]            dec_data;
   logic [1:0]             dec_len;
   logic                   dec_jump;

   // The three MCU lines are asynchronous to clk, so each goes through its own
   // synchroniser chain. The chains hold 0 in reset; an idle-high xlat then
   // only produces a rising edge afterwards, which never triggers a latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_sync <= '0;
         clok_sync <= '0;
         xlat_sync <= '0;
      end else begin
         data_sync <= {data_sync[SYNC_STAGES-2:0], data};
         clok_sync <= {clok_sync[SYNC_STAGES-2:0], clok};
         xlat_sync <= {xlat_sync[SYNC_STAGES-2:0], xlat};
      end
   end

   assign data_s = data_sync[SYNC_STAGES-1];
   assign clok_s = clok_sync[SYNC_STAGES-1];
   assign xlat_s = xlat_sync[SYNC_STAGES-1];

   // A clok rise is only honoured while xlat is high, with one exception: when
   // it lands in the same cycle as the xlat fall, the bit still belongs to the
   // word being latched. Checking xlat_d as well as xlat_s covers that cycle.
   assign shift_req = clok_s & ~clok_d & (xlat_s | xlat_d);
   assign latch_req = ~xlat_s & xlat_d;

   // Delayed copies for edge detection, then the detected edges and the data
   // bit are registered together so the FSM sees them aligned in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clok_d <= 1'b0;
         xlat_d <= 1'b0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         bit_r  <= 1'b0;
      end else begin
         clok_d <= clok_s;
         xlat_d <= xlat_s;
         rise_r <= shift_req;
         fall_r <= latch_req;
         bit_r  <= data_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic plus the post-shift word and count. The shift is always
   // applied first, so a latch in the same cycle sees the updated values. Once
   // the count would pass MAX_BITS the word is unusable: park in OVFL with the
   // count saturated and ignore further bits until the next latch.
   always_comb begin
      state_n    = state;
      shift_word = shreg;
      shift_cnt  = bit_cnt;
      if (rise_r && state != OVFL) begin
         if (bit_cnt == CNT_W'(MAX_BITS)) begin
            state_n   = OVFL;
            shift_cnt = CNT_W'(MAX_BITS + 1);
         end else begin
            state_n    = SHIFT;
            shift_word = {shreg[MAX_BITS-2:0], bit_r};
            shift_cnt  = bit_cnt + 1'b1;
         end
      end
      if (fall_r) begin
         state_n = IDLE;
      end
   end

   // Shift register and bit counter. On a latch the post-shift word and count
   // are copied aside for checking in the next cycle, and the live register
   // starts over empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         lat_word <= '0;
         lat_cnt  <= '0;
         lat_pend <= 1'b0;
      end else begin
         lat_pend <= fall_r;
         if (fall_r) begin
            lat_word <= shift_word;
            lat_cnt  <= shift_cnt;
            shreg    <= '0;
            bit_cnt  <= '0;
         end else begin
            shreg   <= shift_word;
            bit_cnt <= shift_cnt;
         end
      end
   end

   // Word decode. Only 8, 16 and 24 bits form a legal word; the address is
   // always the top nibble and the tracking field is the upper two bits of the
   // low nibble of the first byte, whose position depends on the length.
   always_comb begin
      w24      = 24'(lat_word);
      dec_ok   = 1'b0;
      dec_addr = 4'h0;
      dec_data = 20'h0;
      dec_len  = 2'd0;
      dec_jump = 1'b0;
      case (lat_cnt)
         CNT_W'(8): begin
            dec_ok   = 1'b1;
            dec_addr = w24[7:4];
            dec_data = {16'h0, w24[3:0]};
            dec_len  = 2'd1;
            dec_jump = w24[3];
         end
         CNT_W'(16): begin
            dec_ok   = 1'b1;
            dec_addr = w24[15:12];
            dec_data = {8'h0, w24[11:0]};
            dec_len  = 2'd2;
            dec_jump = w24[11];
         end
         CNT_W'(24): begin
            dec_ok   = 1'b1;
            dec_addr = w24[23:20];
            dec_data = w24[19:0];
            dec_len  = 2'd3;
            dec_jump = w24[19];
         end
         default: begin
            dec_ok = 1'b0;
         end
      endcase
   end

   // Output register. A rejected latch only pulses len_err; everything else
   // holds. jump_active follows the tracking field (10/11 = jump, 00/01 = servo
   // off/on) and is written only by tracking-mode words, so a repeated jump
   // command rewrites 1 over 1 without a glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_addr    <= 4'h0;
         cmd_data    <= 20'h0;
         cmd_len     <= 2'd0;
         cmd_strobe  <= 1'b0;
         len_err     <= 1'b0;
         jump_active <= 1'b0;
      end else begin
         cmd_strobe <= lat_pend & dec_ok;
         len_err    <= lat_pend & ~dec_ok;
         if (lat_pend && dec_ok) begin
            cmd_addr <= dec_addr;
            cmd_data <= dec_data;
            cmd_len  <= dec_len;
            if (dec_addr == TRK_ADDR) begin
               jump_active <= dec_jump;
            end
         end
      end
   end

endmodule
